fighter_motion_ctrl: RTL and testbench
======================================

// Module: fighter_motion_ctrl
// PURPOSE
// - Per-frame producer of fighter position/motion consumed by the sprite animation selectors (motionx, spriteX, spriteY).
// - Decodes keyboard keycode into walk-left/walk-right/jump and integrates position once per frame (vsync rising edge).
// - Runs in the vga_clk domain; vsync is treated as an async input and synchronised internally.
// PARAMETERS
// - X_MIN     10'd0    leftmost legal spriteX
// - X_MAX     10'd549  rightmost legal spriteX (640 - sprite width 90 - 1)
// - X_START   10'd100  spriteX after reset
// - Y_GROUND  10'd300  spriteY when standing
// - STEP      10'd2    horizontal pixels per frame while walking
// - JUMP_V0   6'd12    initial upward velocity, pixels/frame
// - GRAVITY   6'd1     velocity decrement per frame
// - KEY_LEFT  8'h04 (A), KEY_RIGHT 8'h07 (D), KEY_JUMP 8'h1A (W)
// PORTS
// - vga_clk     in   1   pixel clock, all state on posedge
// - reset_n     in   1   asynchronous, active-low reset
// - vsync       in   1   frame sync from VGA controller, asynchronous to logic
// - keycode     in   8   current keyboard keycode, 8'h00 = none
// - frame_tick  out  1   one-cycle pulse on each detected vsync rising edge
// - motionx     out  10  signed two's complement horizontal step applied this frame
// - spriteX     out  10  sprite left edge
// - spriteY     out  10  sprite top edge
// - facing_r    out  1   1 = facing right, 0 = left
// - airborne    out  1   1 while in a jump state
// BEHAVIOUR
// - Reset (async assert, sync-safe release): spriteX=X_START, spriteY=Y_GROUND, motionx=0, facing_r=1, airborne=0,
//   frame_tick=0, vy=0, state=GROUND, sync flops=0.
// - vsync passes a 2-flop synchroniser plus edge flop; frame_tick=1 exactly one cycle after the edge is seen.
//   Latency from vsync rise to frame_tick: 3 vga_clk cycles. Outputs update in the cycle after frame_tick.
// - All outputs hold between frame ticks; keycode is sampled only in the frame_tick cycle.
// - Horizontal, every tick: KEY_LEFT -> req=-STEP, facing_r=0; KEY_RIGHT -> req=+STEP, facing_r=1; other -> req=0.
//   Clamp: if spriteX+req < X_MIN -> spriteX=X_MIN; if > X_MAX -> spriteX=X_MAX; motionx = actual displacement
//   (0 when pinned at a wall) so downstream animation shows idle/breathing, not walking.
//   Arithmetic in 11-bit signed to avoid wrap; never wraps past 0 or 639.
// - FSM states: GROUND, RISE, FALL.
//   GROUND: keycode==KEY_JUMP on tick -> RISE, vy=JUMP_V0, airborne=1 (spriteY unchanged this tick).
//   RISE: each tick spriteY -= vy, vy -= GRAVITY; when vy reaches 0 -> FALL.
//   FALL: each tick vy += GRAVITY, spriteY += vy; if result >= Y_GROUND -> spriteY=Y_GROUND, vy=0, airborne=0, GROUND.
//   spriteY never below 0: upward result < 0 clamps to 0 and forces FALL.
// - Jump key while airborne is ignored (no double jump). Left/right remain active while airborne.
// - Simultaneous reset and tick: reset wins. Reset mid-jump returns to GROUND at Y_GROUND immediately.
// - Missing vsync: no state change; frame_tick stays 0.
// CONFIGURATION
// - FIGHTER_JUMP_EN defined: full GROUND/RISE/FALL behaviour as above.
// - FIGHTER_JUMP_EN undefined: FSM, vy logic removed; KEY_JUMP treated as "no key" (motionx=0);
//   spriteY tied to Y_GROUND, airborne tied to 0. Horizontal behaviour unchanged.
// TESTING
// - Reset, no vsync for 1000 cycles -> spriteX=100, spriteY=300, motionx=0, facing_r=1, frame_tick never 1.
// - keycode=8'h07, 10 vsync pulses -> spriteX=120, motionx=10'd2 each frame, facing_r=1, one frame_tick per pulse, 3-cycle latency.
// - spriteX driven to 1 then keycode=8'h04, 2 frames -> frame1 spriteX=0 motionx=10'h3FF(-1); frame2 spriteX=0 motionx=0.
// - keycode=8'h1A one frame then 00 -> airborne=1, spriteY min=300-78=222 at apex, back to 300 after 24 frames total, airborne=0.
// - Mid-jump (frame 5) pulse reset_n low 2 cycles -> spriteY=300, airborne=0 asynchronously; next jump key restarts from V0=12.
// - FIGHTER_JUMP_EN undefined: keycode=8'h1A for 10 frames -> spriteY=300, motionx=0, airborne=0 throughout.

Source files
------------

// File: rtl/fighter_motion_ctrl.sv
// Fighter position/motion integrator: keycode walk/jump sampled once per frame. Optional jump via FIGHTER_JUMP_EN.
// Latency: vsync rise -> frame_tick 3 vga_clk, outputs 1 cycle later; no backpressure, outputs hold between ticks.
module fighter_motion_ctrl #(
   parameter logic [9:0] X_MIN     = 10'd0,
   parameter logic [9:0] X_MAX     = 10'd549,
   parameter logic [9:0] X_START   = 10'd100,
   parameter logic [9:0] Y_GROUND  = 10'd300,
   parameter logic [9:0] STEP      = 10'd2,
`ifdef FIGHTER_JUMP_EN
   parameter logic [5:0] JUMP_V0   = 6'd12,
   parameter logic [5:0] GRAVITY   = 6'd1,
   parameter logic [7:0] KEY_JUMP  = 8'h1A,
`endif
   parameter logic [7:0] KEY_LEFT  = 8'h04,
   parameter logic [7:0] KEY_RIGHT = 8'h07
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       vsync,
   input  logic [7:0] keycode,
   output logic       frame_tick,
   output logic [9:0] motionx,
   output logic [9:0] spriteX,
   output logic [9:0] spriteY,
   output logic       facing_r,
   output logic       airborne
);

   logic vs_meta, vs_sync, vs_prev;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_meta    <= 1'b0;
         vs_sync    <= 1'b0;
         vs_prev    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         vs_meta    <= vsync;
         vs_sync    <= vs_meta;
         vs_prev    <= vs_sync;
         frame_tick <= vs_sync & ~vs_prev;
      end
   end

   // Horizontal step in 11-bit signed so clamping sees the true sum, never a wrapped one.
   logic signed [10:0] x_req, x_sum, x_next, x_disp;
   logic               face_next;

   always_comb begin
      x_req     = '0;
      face_next = facing_r;
      if (keycode == KEY_LEFT) begin
         x_req     = -$signed({1'b0, STEP});
         face_next = 1'b0;
      end else if (keycode == KEY_RIGHT) begin
         x_req     = $signed({1'b0, STEP});
         face_next = 1'b1;
      end
      x_sum = $signed({1'b0, spriteX}) + x_req;
      if (x_sum < $signed({1'b0, X_MIN}))
         x_next = $signed({1'b0, X_MIN});
      else if (x_sum > $signed({1'b0, X_MAX}))
         x_next = $signed({1'b0, X_MAX});
      else
         x_next = x_sum;
      x_disp = x_next - $signed({1'b0, spriteX});
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         spriteX  <= X_START;
         motionx  <= '0;
         facing_r <= 1'b1;
      end else if (frame_tick) begin
         spriteX  <= x_next[9:0];
         motionx  <= x_disp[9:0];
         facing_r <= face_next;
      end
   end

`ifdef FIGHTER_JUMP_EN
   typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

   state_t      state, state_nx;
   logic [5:0]  vy, vy_nx, vy_inc;
   logic [9:0]  y_nx;
   logic        air_nx;
   logic [10:0] y_up, y_dn;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= GROUND;
         vy       <= '0;
         spriteY  <= Y_GROUND;
         airborne <= 1'b0;
      end else if (frame_tick) begin
         state    <= state_nx;
         vy       <= vy_nx;
         spriteY  <= y_nx;
         airborne <= air_nx;
      end
   end

   always_comb begin
      state_nx = state;
      vy_nx    = vy;
      y_nx     = spriteY;
      air_nx   = airborne;
      vy_inc   = vy + GRAVITY;
      y_up     = {1'b0, spriteY} - {5'b0, vy};
      y_dn     = {1'b0, spriteY} + {5'b0, vy_inc};
      case (state)
         GROUND: begin
            if (keycode == KEY_JUMP) begin
               state_nx = RISE;
               vy_nx    = JUMP_V0;
               air_nx   = 1'b1;
            end
         end
         RISE: begin
            // Hitting the top of the screen ends the ascent early.
            if (y_up[10]) begin
               y_nx     = '0;
               vy_nx    = '0;
               state_nx = FALL;
            end else begin
               y_nx = y_up[9:0];
               if (vy <= GRAVITY) begin
                  vy_nx    = '0;
                  state_nx = FALL;
               end else begin
                  vy_nx = vy - GRAVITY;
               end
            end
         end
         FALL: begin
            vy_nx = vy_inc;
            if (y_dn >= {1'b0, Y_GROUND}) begin
               y_nx     = Y_GROUND;
               vy_nx    = '0;
               air_nx   = 1'b0;
               state_nx = GROUND;
            end else begin
               y_nx = y_dn[9:0];
            end
         end
         default: begin
            state_nx = GROUND;
            vy_nx    = '0;
            y_nx     = Y_GROUND;
            air_nx   = 1'b0;
         end
      endcase
   end
`else
   assign spriteY  = Y_GROUND;
   assign airborne = 1'b0;
`endif

endmodule

// File: tb/tb_fighter_motion_ctrl.sv
// Randomized bench for fighter_motion_ctrl against a frame-level reference model.
module tb_fighter_motion_ctrl;

   logic       vga_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       vsync   = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic       frame_tick;
   logic [9:0] motionx, spriteX, spriteY;
   logic       facing_r, airborne;

   int n_chk  = 0;
   int n_fail = 0;
   int tick_cnt = 0;
   int frames_sent = 0;

   // reference model state
   int m_x, m_dx, m_y, m_face, m_air, m_jidx;
   int traj[$];

   always #5 vga_clk = ~vga_clk;

   fighter_motion_ctrl dut (
      .vga_clk    (vga_clk),
      .reset_n    (reset_n),
      .vsync      (vsync),
      .keycode    (keycode),
      .frame_tick (frame_tick),
      .motionx    (motionx),
      .spriteX    (spriteX),
      .spriteY    (spriteY),
      .facing_r   (facing_r),
      .airborne   (airborne)
   );

   always @(negedge vga_clk) if (frame_tick === 1'b1) tick_cnt++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Jump height above ground for each frame after the jump frame, from the kinematic rules.
   task automatic build_traj();
      int h, v;
      h = 0;
      v = 12;
      traj.delete();
      while (v > 0) begin
         h += v;
         v -= 1;
         traj.push_back(h);
      end
      while (1) begin
         v += 1;
         h -= v;
         if (h <= 0) begin
            traj.push_back(0);
            break;
         end
         traj.push_back(h);
      end
   endtask

   task automatic model_reset();
      m_x = 100; m_dx = 0; m_y = 300; m_face = 1; m_air = 0; m_jidx = 0;
   endtask

   task automatic model_frame(input logic [7:0] k);
      int req, nx;
      req = 0;
      if (k == 8'h04) begin req = -2; m_face = 0; end
      else if (k == 8'h07) begin req = 2; m_face = 1; end
      nx = m_x + req;
      if (nx < 0) nx = 0;
      if (nx > 549) nx = 549;
      m_dx = nx - m_x;
      m_x  = nx;
`ifdef FIGHTER_JUMP_EN
      if (m_air != 0) begin
         m_y = 300 - traj[m_jidx];
         m_jidx++;
         if (m_jidx == traj.size()) m_air = 0;
      end else if (k == 8'h1A) begin
         m_air  = 1;
         m_jidx = 0;
      end
`endif
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".spriteX"},  32'(spriteX),  32'(m_x));
      chk({tag, ".spriteY"},  32'(spriteY),  32'(m_y));
      chk({tag, ".motionx"},  32'(motionx),  32'(m_dx & 32'h3FF));
      chk({tag, ".facing_r"}, 32'(facing_r), 32'(m_face));
      chk({tag, ".airborne"}, 32'(airborne), 32'(m_air));
   endtask

   // One vsync pulse carrying keycode k; checks tick latency, the one-cycle pulse and all outputs.
   task automatic do_frame(input logic [7:0] k);
      int lat;
      bit seen;
      lat  = 0;
      seen = 0;
      keycode = k;
      vsync   = 1'b1;
      frames_sent++;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge vga_clk);
         lat++;
         if (frame_tick === 1'b1) seen = 1;
      end
      chk("tick_latency", 32'(lat), 32'd3);
      @(negedge vga_clk);
      chk("tick_width", 32'(frame_tick), 32'd0);
      model_frame(k);
      check_outputs("frame");
      vsync   = 1'b0;
      keycode = 8'($urandom);
      repeat (5) @(negedge vga_clk);
   endtask

   initial begin
      int min_y, land, ticks0;
      logic [7:0] k;

      build_traj();
      model_reset();
      repeat (3) @(negedge vga_clk);
      reset_n = 1'b1;

      // No vsync: everything holds at reset values.
      repeat (1000) @(negedge vga_clk);
      check_outputs("idle");
      chk("idle_ticks", 32'(tick_cnt), 32'd0);

      // Walk right ten frames.
      for (int i = 0; i < 10; i++) do_frame(8'h07);
      chk("walk10_x", 32'(spriteX), 32'd120);

      // Pin against the right wall, then walk all the way to the left wall (odd -> 0 gives -1).
      for (int i = 0; i < 230; i++) do_frame(8'h07);
      for (int i = 0; i < 276; i++) do_frame(8'h04);
      chk("left_wall_x", 32'(spriteX), 32'd0);

      // Single jump, then idle keys until landing.
      do_frame(8'h1A);
      min_y = 1023;
      land  = 0;
      for (int i = 0; i < 30; i++) begin
         do_frame(8'h00);
         if (spriteY < min_y) min_y = spriteY;
         if (land == 0 && airborne == 1'b0) land = i + 1;
      end
`ifdef FIGHTER_JUMP_EN
      chk("jump_apex", 32'(min_y), 32'd222);
      chk("jump_frames", 32'(land), 32'd24);
`else
      chk("nojump_y", 32'(min_y), 32'd300);
`endif

      // Reset in the middle of a jump.
      do_frame(8'h1A);
      for (int i = 0; i < 5; i++) do_frame(8'h00);
      reset_n = 1'b0;
      #1;
      chk("rst_async_y", 32'(spriteY), 32'd300);
      chk("rst_async_air", 32'(airborne), 32'd0);
      chk("rst_async_x", 32'(spriteX), 32'd100);
      chk("rst_async_face", 32'(facing_r), 32'd1);
      repeat (2) @(negedge vga_clk);
      reset_n = 1'b1;
      model_reset();
      ticks0 = tick_cnt;
      frames_sent = 0;
      do_frame(8'h1A);
      do_frame(8'h00);
      do_frame(8'h00);

      // Random key mix.
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 4))
            0: k = 8'h00;
            1: k = 8'h04;
            2: k = 8'h07;
            3: k = 8'h1A;
            default: k = 8'($urandom);
         endcase
         do_frame(k);
      end

      chk("tick_count", 32'(tick_cnt - ticks0), 32'(frames_sent));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
